// File: rtl/note_player_pkg.sv
// Shared types and default sizes for the note_player block and its tone divider.
// The GAP state is only reachable when NOTE_PLAYER_GAP_EN is defined.
package note_player_pkg;

    localparam int PERIOD_W_DEF  = 20;
    localparam int DUR_W_DEF     = 6;
    localparam int BEATS_PER_SEC = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/note_player_tone_divider.sv
// Half-period counter plus toggle flop producing the note's square wave.
// A half_period of 0 is a rest: the counter idles and the output stays low.
module tone_divider
    import note_player_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] i_half_period,
    input  logic                i_enable,
    input  logic                i_clear,
    output logic                o_tone
);

    logic [PERIOD_W-1:0] r_count;
    logic                r_tone;
    logic                w_rest;
    logic                w_wrap;

    assign w_rest = (i_half_period == '0);
    assign w_wrap = !w_rest && (r_count == i_half_period - PERIOD_W'(1));

    // Clear has priority so a note-end beat beats a same-cycle toggle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_tone  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_tone  <= 1'b0;
        end else if (i_enable && !w_rest) begin
            if (w_wrap) begin
                r_count <= '0;
                r_tone  <= ~r_tone;
            end else begin
                r_count <= r_count + PERIOD_W'(1);
            end
        end
    end

    assign o_tone = r_tone;

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: aligns to the next beat, toggles tone_out for the
// note's duration in beats, then pulses done. Optional NOTE_PLAYER_GAP_EN adds a silent beat.
module note_player
    import note_player_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int DUR_W    = DUR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                beat,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [PERIOD_W-1:0] note_half_period,
    input  logic [DUR_W-1:0]    note_duration,
    output logic                tone_out,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    state_t              r_state;
    state_t              w_next_state;
    logic [PERIOD_W-1:0] r_half_period;
    logic [DUR_W-1:0]    r_duration;
    logic [DUR_W-1:0]    r_remaining;
    logic                r_done;
    logic                w_done_next;
    logic                w_accept;
    logic                w_end_beat;
    logic                w_tone_enable;
    logic                w_tone_clear;

    // Handshake: a note transfers on a clk edge where note_valid and note_ready are
    // both high; upstream must hold the note stable until then. Ready stays low in
    // the done cycle so the next note is taken no earlier than one cycle after done.
    assign note_ready = (r_state == ST_IDLE) && !r_done;
    assign w_accept   = note_valid && note_ready;
    assign w_end_beat = (r_state == ST_PLAY) && beat && (r_remaining == DUR_W'(1));

    always_comb begin
        w_next_state = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (note_duration == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_next_state = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                if (beat) begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_end_beat) begin
`ifdef NOTE_PLAYER_GAP_EN
                    w_next_state = ST_GAP;
`else
                    w_next_state = ST_IDLE;
                    w_done_next  = 1'b1;
`endif
                end
            end
            ST_GAP: begin
`ifdef NOTE_PLAYER_GAP_EN
                if (beat) begin
                    w_next_state = ST_IDLE;
                    w_done_next  = 1'b1;
                end
`else
                w_next_state = ST_IDLE;
`endif
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_half_period <= '0;
            r_duration    <= '0;
            r_remaining   <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_accept) begin
                r_half_period <= note_half_period;
                r_duration    <= note_duration;
            end
            // Beat counting starts at the aligning beat, not the acceptance cycle.
            if ((r_state == ST_ALIGN) && beat) begin
                r_remaining <= r_duration;
            end else if ((r_state == ST_PLAY) && beat && (r_remaining != '0)) begin
                r_remaining <= r_remaining - DUR_W'(1);
            end
        end
    end

    assign w_tone_enable = (r_state == ST_PLAY);
    assign w_tone_clear  = (r_state != ST_PLAY) || w_end_beat;

    tone_divider #(
        .PERIOD_W(PERIOD_W)
    ) u_tone_divider (
        .clk          (clk),
        .reset        (reset),
        .i_half_period(r_half_period),
        .i_enable     (w_tone_enable),
        .i_clear      (w_tone_clear),
        .o_tone       (tone_out)
    );

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: driver tasks push expected per-note responses
// into exp_q; a monitor pops and compares on every done pulse.
module tb_note_player;
    import note_player_pkg::*;

    localparam int PW = 20;
    localparam int DW = 6;
    localparam int RW = 48;
    localparam int BP = 20;
`ifdef NOTE_PLAYER_GAP_EN
    localparam int GAP_BEATS = 1;
`else
    localparam int GAP_BEATS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          beat = 1'b0;
    logic          note_valid = 1'b0;
    logic [PW-1:0] note_half_period = '0;
    logic [DW-1:0] note_duration = '0;
    logic          note_ready;
    logic          tone_out;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bcnt = 0;
    logic [RW-1:0] exp_q[$];

    note_player #(.PERIOD_W(PW), .DUR_W(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .beat            (beat),
        .note_valid      (note_valid),
        .note_ready      (note_ready),
        .note_half_period(note_half_period),
        .note_duration   (note_duration),
        .tone_out        (tone_out),
        .busy            (busy),
        .done            (done),
        .dbg_state       (dbg_state)
    );

    // clock / reset / beat
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        bcnt = (bcnt == BP - 1) ? 0 : bcnt + 1;
        beat = (bcnt == 0);
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] pack_resp(input int lat, input int busy_cyc, input int rises,
                                                input logic t, input logic b, input logic r);
        pack_resp = {lat[15:0], busy_cyc[15:0], rises[12:0], t, b, r};
    endfunction

    // Accept lands off cycles after a beat cycle; the aligning beat is the following one.
    function automatic int lat_for(input int off, input int dur);
        if (dur == 0) return 1;
        return BP + 1 - off + BP * (dur + GAP_BEATS);
    endfunction

    function automatic logic [RW-1:0] expected(input int lat, input int rises);
        return pack_resp(lat, lat - 1, rises, 1'b0, 1'b0, 1'b0);
    endfunction

    // monitor / scoreboard
    int   accept_at = 0;
    int   busy_cnt = 0;
    int   rise_cnt = 0;
    logic prev_tone = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            busy_cnt  = 0;
            rise_cnt  = 0;
            prev_tone = 1'b0;
            if (done) begin
                total++;
                bad++;
                $display("FAIL done_in_reset: got done=1 want 0 (cycle %0d)", cyc);
            end
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 with no note pending (cycle %0d)", cyc);
                end else begin
                    check("note_resp", pack_resp(cyc - accept_at, busy_cnt, rise_cnt, tone_out, busy, note_ready),
                          exp_q.pop_front());
                end
            end
            if (busy) busy_cnt++;
            if (tone_out && !prev_tone) rise_cnt++;
            prev_tone = tone_out;
            if (note_valid && note_ready) begin
                accept_at = cyc;
                busy_cnt  = 0;
                rise_cnt  = 0;
            end
        end
    end

    // driver tasks
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (note_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                total++;
                bad++;
                $display("FAIL idle_timeout: got note_ready=%0b want 1", note_ready);
                return;
            end
        end
    endtask

    task automatic sync_beat(input int off);
        do begin
            @(posedge clk);
            #2;
        end while (!beat);
        for (int i = 0; i < off; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic handshake();
        int n = 0;
        forever begin
            @(negedge clk);
            if (note_ready) break;
            n++;
            if (n > 3000) begin
                total++;
                bad++;
                $display("FAIL handshake_timeout: got note_ready=0 want 1");
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic send_note(input int hp, input int dur, input int off, input int rises, input bit push);
        wait_idle();
        sync_beat(off);
        note_half_period = PW'(hp);
        note_duration    = DW'(dur);
        note_valid       = 1'b1;
        if (push) exp_q.push_back(expected(lat_for(off, dur), rises));
        handshake();
        note_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 5000) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    initial begin
        #20000000;
        total++;
        bad++;
        $display("FAIL watchdog: got no finish want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tone", RW'(tone_out), RW'(0));
        check("rst_done", RW'(done), RW'(0));
        check("rst_busy", RW'(busy), RW'(0));
        check("rst_ready", RW'(note_ready), RW'(1));
        check("rst_state", RW'(dbg_state), RW'(ST_IDLE));
        @(posedge clk);
        #2 reset = 1'b1;

        // basic note, accepted in a beat cycle; beat there must be ignored
        send_note(4, 2, 0, 5, 1'b1);
        @(negedge clk);
        check("align_state", RW'(dbg_state), RW'(ST_ALIGN));
        check("align_tone", RW'(tone_out), RW'(0));
        wait_drain();

        // null note
        send_note(4, 0, 5, 0, 1'b1);
        wait_drain();
        @(negedge clk);
        check("null_ready_back", RW'(note_ready), RW'(1));

        // rest note
        send_note(0, 3, 0, 0, 1'b1);
        wait_drain();

        // wrap coincident with the end beat
        send_note(5, 1, 7, 2, 1'b1);
        wait_drain();
        send_note(4, 1, 0, 2, 1'b1);
        wait_drain();
        send_note(3, 1, 19, 3, 1'b1);
        wait_drain();

        // reset mid-PLAY after one of three beats
        send_note(4, 3, 0, 0, 1'b0);
        repeat (50) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tone", RW'(tone_out), RW'(0));
        check("mid_rst_busy", RW'(busy), RW'(0));
        check("mid_rst_ready", RW'(note_ready), RW'(1));
        check("mid_rst_done", RW'(done), RW'(0));
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (100) @(posedge clk);
        send_note(4, 1, 3, 2, 1'b1);
        wait_drain();

        // back-to-back: second note held valid through the first
        wait_idle();
        sync_beat(0);
        note_half_period = PW'(4);
        note_duration    = DW'(1);
        note_valid       = 1'b1;
        exp_q.push_back(expected(lat_for(0, 1), 2));
        handshake();
        note_half_period = PW'(6);
        note_duration    = DW'(1);
        exp_q.push_back(expected(BP - 1 + BP * (1 + GAP_BEATS), 2));
        handshake();
        note_valid = 1'b0;
        wait_drain();

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
